game_tick_ramp: RTL and testbench

Parametrised game-speed clock generator and the successor of the fixed-rate game clock. It divides the system clock into a square wave, `div_out`, and a matching one-cycle `tick` strobe. After every TOGGLES_PER_LEVEL toggles it shortens the half-period by STEP, clamping at a floor. It adds run/pause, synchronous restart, and level/status outputs for the game FSM and score display.

---
 rtl/game_tick_ramp.sv | 168 ++++++++++++++++
 tb/tb_game_tick_ramp.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/game_tick_ramp.sv
// -----------------------------------------------------------------------------
// game_tick_ramp
//
// Game-speed clock generator. Divides clk into a square wave (div_out) whose
// half-period is (terminal count + 1) clk cycles, and emits a one-cycle tick
// in the cycle after each div_out toggle. Every TOGGLES_PER_LEVEL toggles the
// terminal count is reduced by STEP, clamped at MIN_DIV, so the game speeds up
// over time. run pauses everything; restart reloads the power-on state.
//
// Ports:
//   clk      in   system clock (single domain)
//   rst      in   asynchronous reset, active-high
//   run      in   1 = counting, 0 = hold all state (tick forced low)
//   restart  in   synchronous reload to reset state; overrides run
//   div_out  out  divided square wave, 1 out of reset
//   tick     out  one-cycle pulse in the cycle after each div_out toggle
//   level    out  number of speed-ups applied, saturating at all-ones
//   at_max   out  1 when the terminal count has reached MIN_DIV
//   cur_div  out  current terminal count
// -----------------------------------------------------------------------------
module game_tick_ramp #(
  parameter int CNT_W             = 28,
  parameter int INIT_DIV          = 200000,
  parameter int MIN_DIV           = 100000,
  parameter int STEP              = 20000,
  parameter int TOGGLES_PER_LEVEL = 10000,
  parameter int FULL_W            = 15,
  parameter int LVL_W             = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             restart,
  output logic             div_out,
  output logic             tick,
  output logic [LVL_W-1:0] level,
  output logic             at_max,
  output logic [CNT_W-1:0] cur_div
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter legality
  // ---------------------------------------------------------------------------
  if (!((MIN_DIV <= INIT_DIV) && (longint'(INIT_DIV) < (longint'(1) << CNT_W))))
  begin : g_bad_div
    $error("game_tick_ramp: need MIN_DIV <= INIT_DIV < 2**CNT_W");
  end
  if (STEP < 1) begin : g_bad_step
    $error("game_tick_ramp: STEP must be >= 1");
  end
  if (!((TOGGLES_PER_LEVEL >= 1) &&
        (longint'(TOGGLES_PER_LEVEL) <= (longint'(1) << FULL_W))))
  begin : g_bad_tpl
    $error("game_tick_ramp: need 1 <= TOGGLES_PER_LEVEL <= 2**FULL_W");
  end

  localparam logic [CNT_W-1:0]  C_INIT      = CNT_W'(INIT_DIV);
  localparam logic [CNT_W-1:0]  C_MIN       = CNT_W'(MIN_DIV);
  localparam logic [CNT_W-1:0]  C_STEP      = CNT_W'(STEP);
  // A STEP that does not fit in CNT_W is always larger than any gap, so the
  // speed-up must clamp instead of subtracting a truncated value.
  localparam bit                C_STEP_FITS = longint'(STEP) < (longint'(1) << CNT_W);
  localparam logic [FULL_W-1:0] C_FULL_LAST = FULL_W'(TOGGLES_PER_LEVEL - 1);
  localparam logic [LVL_W-1:0]  C_LVL_MAX   = '1;
  localparam logic              C_AT_MAX_RST = (INIT_DIV == MIN_DIV);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  r_div;
  logic [FULL_W-1:0] r_full;
  logic              r_div_out;
  logic              r_tick;
  logic [LVL_W-1:0]  r_level;
  logic              r_at_max;

  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [CNT_W-1:0]  w_div_nxt;
  logic [FULL_W-1:0] w_full_nxt;
  logic              w_div_out_nxt;
  logic              w_tick_nxt;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              w_toggle;
  logic              w_level_up;
  logic [CNT_W-1:0]  w_gap;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    w_cnt_nxt     = r_cnt;
    w_div_nxt     = r_div;
    w_full_nxt    = r_full;
    w_div_out_nxt = r_div_out;
    w_tick_nxt    = 1'b0;
    w_level_nxt   = r_level;
    w_toggle      = run && (r_cnt >= r_div);
    w_level_up    = w_toggle && (r_full == C_FULL_LAST);
    // r_div never drops below C_MIN, so this gap cannot wrap.
    w_gap         = r_div - C_MIN;

    if (run) begin
      if (w_toggle) begin
        w_cnt_nxt     = '0;
        w_div_out_nxt = ~r_div_out;
        w_tick_nxt    = 1'b1;
        w_full_nxt    = w_level_up ? '0 : r_full + FULL_W'(1);
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end

    if (w_level_up) begin
      if (C_STEP_FITS && (w_gap >= C_STEP)) begin
        w_div_nxt = r_div - C_STEP;
      end else if (r_div > C_MIN) begin
        w_div_nxt = C_MIN;
      end
      // Level only counts speed-ups that actually changed the period.
      if ((w_div_nxt != r_div) && (r_level != C_LVL_MAX)) begin
        w_level_nxt = r_level + LVL_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      r_cnt     <= '0;
      r_div     <= C_INIT;
      r_full    <= '0;
      r_div_out <= 1'b1;
      r_tick    <= 1'b0;
      r_level   <= '0;
      r_at_max  <= C_AT_MAX_RST;
    end else if (restart) begin
      r_cnt     <= '0;
      r_div     <= C_INIT;
      r_full    <= '0;
      r_div_out <= 1'b1;
      r_tick    <= 1'b0;
      r_level   <= '0;
      r_at_max  <= C_AT_MAX_RST;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_div     <= w_div_nxt;
      r_full    <= w_full_nxt;
      r_div_out <= w_div_out_nxt;
      r_tick    <= w_tick_nxt;
      r_level   <= w_level_nxt;
      r_at_max  <= (w_div_nxt == C_MIN);
    end
  end

  assign div_out = r_div_out;
  assign tick    = r_tick;
  assign level   = r_level;
  assign at_max  = r_at_max;
  assign cur_div = r_div;

endmodule

// File: tb/tb_game_tick_ramp.sv
// -----------------------------------------------------------------------------
// tb_game_tick_ramp
//
// Two instances: u_dut (INIT_DIV=9, MIN_DIV=3, STEP=4, 2 toggles per level,
// LVL_W=2) and u_dut2 (INIT_DIV=20, MIN_DIV=2, STEP=4, 1 toggle per level,
// LVL_W=1). Expected tick records are pushed onto a queue and popped as each
// tick appears; pause, restart and async-reset corners are hand sequences.
// -----------------------------------------------------------------------------
module tb_game_tick_ramp;

  logic       clk = 1'b0;
  logic       rst;
  logic       run, restart, run2, restart2;

  logic       div_out, tick, at_max;
  logic [1:0] level;
  logic [7:0] cur_div;

  logic       div_out2, tick2, at_max2;
  logic [0:0] level2;
  logic [7:0] cur_div2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int gap;      // clk edges since the previous tick (or since start)
    int div_out;
    int cur_div;
    int level;
    int at_max;
  } tick_exp_t;

  tick_exp_t exp_q[$];
  tick_exp_t tab1[7];
  tick_exp_t tab6[7];

  always #5 clk = ~clk;

  game_tick_ramp #(
    .CNT_W(8), .INIT_DIV(9), .MIN_DIV(3), .STEP(4),
    .TOGGLES_PER_LEVEL(2), .FULL_W(2), .LVL_W(2)
  ) u_dut (
    .clk(clk), .rst(rst), .run(run), .restart(restart),
    .div_out(div_out), .tick(tick), .level(level),
    .at_max(at_max), .cur_div(cur_div)
  );

  game_tick_ramp #(
    .CNT_W(8), .INIT_DIV(20), .MIN_DIV(2), .STEP(4),
    .TOGGLES_PER_LEVEL(1), .FULL_W(1), .LVL_W(1)
  ) u_dut2 (
    .clk(clk), .rst(rst), .run(run2), .restart(restart2),
    .div_out(div_out2), .tick(tick2), .level(level2),
    .at_max(at_max2), .cur_div(cur_div2)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clk edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input bit sel, input int budget, output int gap);
    bit done;
    done = 1'b0;
    gap  = 0;
    while (!done) begin
      step();
      gap++;
      if ((sel ? tick2 : tick) === 1'b1) begin
        done = 1'b1;
      end else if (gap >= budget) begin
        checks++;
        errors++;
        $display("FAIL tick_timeout: no tick within %0d cycles (dut%0d)",
                 budget, sel ? 2 : 1);
        done = 1'b1;
      end
    end
  endtask

  // Pop expected tick records and compare against each observed tick.
  task automatic run_queue(input bit sel, input string tag);
    tick_exp_t e;
    int        gap;
    int        n;
    n = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n++;
      wait_tick(sel, e.gap + 3, gap);
      check($sformatf("%s_t%0d_gap", tag, n), 32'(gap), 32'(e.gap));
      if (sel) begin
        check($sformatf("%s_t%0d_div_out", tag, n), 32'(div_out2), 32'(e.div_out));
        check($sformatf("%s_t%0d_cur_div", tag, n), 32'(cur_div2), 32'(e.cur_div));
        check($sformatf("%s_t%0d_level", tag, n),   32'(level2),   32'(e.level));
        check($sformatf("%s_t%0d_at_max", tag, n),  32'(at_max2),  32'(e.at_max));
      end else begin
        check($sformatf("%s_t%0d_div_out", tag, n), 32'(div_out), 32'(e.div_out));
        check($sformatf("%s_t%0d_cur_div", tag, n), 32'(cur_div), 32'(e.cur_div));
        check($sformatf("%s_t%0d_level", tag, n),   32'(level),   32'(e.level));
        check($sformatf("%s_t%0d_at_max", tag, n),  32'(at_max),  32'(e.at_max));
      end
    end
  endtask

  task automatic check_state(input string tag, input int e_do, input int e_tick,
                             input int e_div, input int e_lvl, input int e_max);
    check({tag, "_div_out"}, 32'(div_out), 32'(e_do));
    check({tag, "_tick"},    32'(tick),    32'(e_tick));
    check({tag, "_cur_div"}, 32'(cur_div), 32'(e_div));
    check({tag, "_level"},   32'(level),   32'(e_lvl));
    check({tag, "_at_max"},  32'(at_max),  32'(e_max));
  endtask

  initial begin
    int gap;

    // Free-run expectations for u_dut: spacing 10,10,6,6,4,4,4.
    tab1[0] = '{10, 0, 9, 0, 0};
    tab1[1] = '{10, 1, 5, 1, 0};
    tab1[2] = '{ 6, 0, 5, 1, 0};
    tab1[3] = '{ 6, 1, 3, 2, 1};
    tab1[4] = '{ 4, 0, 3, 2, 1};
    tab1[5] = '{ 4, 1, 3, 2, 1};
    tab1[6] = '{ 4, 0, 3, 2, 1};
    // u_dut2: speed-up on every toggle, clamp 4 -> 2, level saturates at 1.
    tab6[0] = '{21, 0, 16, 1, 0};
    tab6[1] = '{17, 1, 12, 1, 0};
    tab6[2] = '{13, 0,  8, 1, 0};
    tab6[3] = '{ 9, 1,  4, 1, 0};
    tab6[4] = '{ 5, 0,  2, 1, 1};
    tab6[5] = '{ 3, 1,  2, 1, 1};
    tab6[6] = '{ 3, 0,  2, 1, 1};

    rst = 1'b1; run = 1'b0; restart = 1'b0; run2 = 1'b0; restart2 = 1'b0;

    // 1. Reset state, then release with run=1.
    step(); step();
    check_state("reset", 1, 0, 9, 0, 0);
    check("reset2_cur_div", 32'(cur_div2), 32'd20);
    rst = 1'b0;
    run = 1'b1;

    // 2. Free run through two level-ups and the clamp.
    foreach (tab1[i]) exp_q.push_back(tab1[i]);
    run_queue(1'b0, "free");

    // 3. Pause for 7 cycles with cnt=4.
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_state("restart", 1, 0, 9, 0, 0);
    repeat (4) step();
    run = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check_state($sformatf("pause%0d", i), 1, 0, 9, 0, 0);
    end
    run = 1'b1;
    exp_q.push_back('{6, 0, 9, 0, 0});
    run_queue(1'b0, "unpause");

    // 4. restart on the cycle where cnt == div (div=5 after a level-up).
    exp_q.push_back('{10, 1, 5, 1, 0});
    run_queue(1'b0, "pre_rs");
    repeat (5) step();
    check("pre_rs_no_tick", 32'(tick), 32'd0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check_state("rs_at_term", 1, 0, 9, 0, 0);
    exp_q.push_back('{10, 0, 9, 0, 0});
    exp_q.push_back('{10, 1, 5, 1, 0});
    exp_q.push_back('{ 6, 0, 5, 1, 0});
    run_queue(1'b0, "post_rs");

    // 5. Async reset between edges, right after a tick.
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 1, 0, 9, 0, 0);
    check("async_rst2_cur_div", 32'(cur_div2), 32'd20);
    step();
    rst = 1'b0;
    run = 1'b0;

    // 6. Second instance: single toggle per level, clamp and saturation.
    check("dut2_init_level", 32'(level2), 32'd0);
    check("dut2_init_at_max", 32'(at_max2), 32'd0);
    run2 = 1'b1;
    foreach (tab6[i]) exp_q.push_back(tab6[i]);
    run_queue(1'b1, "dut2");
    check_state("dut1_idle", 1, 0, 9, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
